// File: rtl/source2.sv
`default_nettype none
// ============================================================================
//  Module   : source2
//  Purpose  : Transmitter end of a two-phase (transition-signalled) req/ack
//             channel.  Generates an incrementing sequence of data words and
//             offers each one by toggling req, holding data stable until the
//             receiver answers with an ack transition.  Supports a word count
//             limit, inter-word gap cycles, a sticky handshake timeout flag
//             and a sticky protocol error flag.
//  Ports    : clk          - clock, all state on rising edge
//             reset        - asynchronous active-low reset
//             enable       - permits starting new words
//             ack          - two-phase acknowledge from the receiver
//             req          - two-phase request, each transition offers a word
//             data         - word currently offered
//             sent_count   - number of words acknowledged (wraps at 2^16)
//             done         - high once COUNT words have been acknowledged
//             timeout_err  - sticky, a handshake exceeded TIMEOUT cycles
//             protocol_err - sticky, ack transition with nothing outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module source2 #(
    parameter int ID      = 0,
    parameter int SIZE    = 8,
    parameter int COUNT   = 16,
    parameter int START   = 0,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            ack,
    output logic            req,
    output logic [SIZE-1:0] data,
    output logic [15:0]     sent_count,
    output logic            done,
    output logic            timeout_err,
    output logic            protocol_err
);

    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [15:0]     C_COUNT   = 16'(COUNT);
    localparam logic [SIZE-1:0] C_START   = SIZE'(START);
    localparam logic [GW-1:0]   C_GAP     = GW'(GAP);
    localparam logic [TW-1:0]   C_TIMEOUT = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // ID only tags log output in the original model; reject nonsense values.
    if (ID < 0 || SIZE < 1) begin : g_param_check
        $error("source2: ID must be non-negative and SIZE positive");
    end

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_ack_old;
    logic [GW-1:0] r_gap_cnt;
    logic [TW-1:0] r_tmo_cnt;

    logic w_ack_evt;
    logic w_accept;
    logic w_last;
    logic w_launch;
    logic w_toggle;
    logic w_load_gap;
    logic w_proto;

    assign w_ack_evt = ack ^ r_ack_old;
    // Word that is being acknowledged now is the final one of the run.
    assign w_last    = (COUNT != 0) && ((sent_count + 16'd1) == C_COUNT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = (GAP == 0) ? S_WAIT : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GW'(1)) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ack_evt) begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end else if (enable) begin
                        w_state_next = (GAP == 0) ? S_WAIT : S_GAP;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_DONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = 1'b0;
        w_launch   = 1'b0;
        w_toggle   = 1'b0;
        w_load_gap = 1'b0;
        w_proto    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = enable;
                w_proto  = w_ack_evt;
            end
            S_GAP: begin
                w_toggle = (r_gap_cnt == GW'(1));
                w_proto  = w_ack_evt;
            end
            S_WAIT: begin
                w_accept = w_ack_evt;
                // Accepting a word behaves like IDLE on the same edge.
                w_launch = w_ack_evt && !w_last && enable;
            end
            default: begin
                w_proto = w_ack_evt;
            end
        endcase
        if (w_launch) begin
            if (GAP == 0) begin
                w_toggle = 1'b1;
            end else begin
                w_load_gap = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req          <= 1'b0;
            r_ack_old    <= 1'b0;
            data         <= C_START;
            sent_count   <= 16'd0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            protocol_err <= 1'b0;
            r_gap_cnt    <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_ack_old <= ack;

            if (w_toggle) begin
                req <= ~req;
            end

            if (w_accept) begin
                sent_count <= sent_count + 16'd1;
                data       <= data + SIZE'(1);
                if (w_last) begin
                    done <= 1'b1;
                end
            end

            if (w_load_gap) begin
                r_gap_cnt <= C_GAP;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end

            // Counter restarts with every new request and saturates at
            // TIMEOUT; the flag is raised on the edge the count lands there.
            if (w_toggle) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_ack_evt && (TIMEOUT != 0)
                         && (r_tmo_cnt != C_TIMEOUT)) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
                if ((r_tmo_cnt + TW'(1)) == C_TIMEOUT) begin
                    timeout_err <= 1'b1;
                end
            end

            if (w_proto) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
